// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// steps and drives every datapath mux select and write enable.
module mips_multicycle_ctrl #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       ext_zero,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11,
        S_JMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     state_reg, state_next;
    logic [5:0] opcode_reg;
    logic       mem_ok;
    logic [2:0] imm_alu_op;
    logic       imm_ext_zero;

    // With waits disabled every memory access is treated as completing at once.
    assign mem_ok = WAIT_EN ? mem_ready : 1'b1;
    assign state  = state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            opcode_reg <= 6'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                opcode_reg <= opcode;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (mem_ok) state_next = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW:                      state_next = S_MEMADR;
                    OP_RTYPE:                          state_next = S_REX;
                    OP_BEQ:                            state_next = S_BEQ;
                    OP_J:                              state_next = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IEX;
                    default:                           state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ok) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ok) state_next = S_FETCH;
            S_REX:    state_next = S_RWB;
            S_IEX:    state_next = S_IWB;
            S_MEMWB, S_RWB, S_BEQ, S_IWB, S_JMP: state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Immediate ALU op and extension mode come from the latched opcode.
    always_comb begin
        imm_alu_op   = 3'b000;
        imm_ext_zero = 1'b0;
        unique case (opcode_reg)
            OP_ANDI: begin imm_alu_op = 3'b011; imm_ext_zero = 1'b1; end
            OP_ORI:  begin imm_alu_op = 3'b100; imm_ext_zero = 1'b1; end
            OP_SLTI: imm_alu_op = 3'b101;
            default: ;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        ext_zero      = 1'b0;
        illegal       = 1'b0;
        unique case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal = 1'b0;
                    default:                           illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
                ext_zero  = imm_ext_zero;
            end
            S_IWB: begin
                reg_write = 1'b1;
                alu_op    = imm_alu_op;
                ext_zero  = imm_ext_zero;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a driver issues per-cycle inputs and
// queues the expected control word; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        logic       ez, ill;
    } exp_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;

    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    exp_t exp_q[$];
    exp_t act, got_e;
    int   passed = 0, total = 0, cyc = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .ext_zero(ext_zero), .illegal(illegal), .state(state)
    );

    assign act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, ext_zero, illegal};

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            total++;
            if (act === got_e) passed++;
            else $display("FAIL ctl cycle %0d: got state=%0d word=%h, required state=%0d word=%h",
                          cyc, act.st, act, got_e.st, got_e);
        end
    end

    function automatic exp_t blank(input logic [3:0] s);
        exp_t e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, J, ADDI, ANDI, ORI, SLTI};
    endfunction

    // One cycle: inputs driven just after the edge, expected word queued for that cycle.
    task automatic step(input logic r, input logic mr, input logic [5:0] op, input exp_t e);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = mr;
        opcode = op;
        zero = 1'($urandom);
        exp_q.push_back(e);
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    task automatic do_fetch(input int waits);
        exp_t e = blank(4'd1);
        e.mr = 1'b1;
        e.asb = 2'b01;
        for (int i = 0; i < waits; i++) step(1'b0, 1'b0, junk(), e);
        e.irw = 1'b1;
        e.pw = 1'b1;
        step(1'b0, 1'b1, junk(), e);
    endtask

    task automatic do_decode(input logic [5:0] op);
        exp_t e = blank(4'd2);
        e.asb = 2'b11;
        e.ill = !is_legal(op);
        step(1'b0, 1'($urandom), op, e);
    endtask

    // Memory phase with a given number of not-ready cycles before completion.
    task automatic do_mem(input logic [3:0] s, input bit wr, input int waits);
        exp_t e = blank(s);
        e.iod = 1'b1;
        if (wr) e.mw = 1'b1; else e.mr = 1'b1;
        for (int i = 0; i < waits; i++) step(1'b0, 1'b0, junk(), e);
        step(1'b0, 1'b1, junk(), e);
    endtask

    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        do_fetch(fw);
        do_decode(op);
        // The opcode bus carries junk from here on: execution must use the latched one.
        case (op)
            LW, SW: begin
                e = blank(4'd3); e.asa = 1'b1; e.asb = 2'b10;
                step(1'b0, 1'($urandom), junk(), e);
                if (op == LW) begin
                    do_mem(4'd4, 1'b0, mw);
                    e = blank(4'd5); e.rw = 1'b1; e.m2r = 1'b1;
                    step(1'b0, 1'($urandom), junk(), e);
                end else begin
                    do_mem(4'd6, 1'b1, mw);
                end
            end
            RT: begin
                e = blank(4'd7); e.asa = 1'b1; e.aop = 3'b010;
                step(1'b0, 1'($urandom), junk(), e);
                e = blank(4'd8); e.rw = 1'b1; e.rd = 1'b1;
                step(1'b0, 1'($urandom), junk(), e);
            end
            BEQ: begin
                e = blank(4'd9); e.asa = 1'b1; e.aop = 3'b001; e.pwc = 1'b1; e.ps = 2'b01;
                step(1'b0, 1'($urandom), junk(), e);
            end
            J: begin
                e = blank(4'd12); e.pw = 1'b1; e.ps = 2'b10;
                step(1'b0, 1'($urandom), junk(), e);
            end
            ADDI, ANDI, ORI, SLTI: begin
                e = blank(4'd10); e.asa = 1'b1; e.asb = 2'b10;
                e.aop = (op == ADDI) ? 3'b000 : (op == ANDI) ? 3'b011 :
                        (op == ORI)  ? 3'b100 : 3'b101;
                e.ez = (op == ANDI) || (op == ORI);
                step(1'b0, 1'($urandom), junk(), e);
                e.st = 4'd11; e.asa = 1'b0; e.asb = 2'b00; e.rw = 1'b1;
                step(1'b0, 1'($urandom), junk(), e);
            end
            default: ;
        endcase
    endtask

    task automatic do_reset_mid_memrd();
        exp_t e;
        do_fetch(0);
        do_decode(LW);
        e = blank(4'd3); e.asa = 1'b1; e.asb = 2'b10;
        step(1'b0, 1'b0, junk(), e);
        e = blank(4'd4); e.iod = 1'b1; e.mr = 1'b1;
        step(1'b0, 1'b0, junk(), e);
        step(1'b1, 1'b0, junk(), blank(4'd0));
        step(1'b1, 1'b1, junk(), blank(4'd0));
        step(1'b0, 1'($urandom), junk(), blank(4'd0));
    endtask

    initial begin
        logic [5:0] ops [9] = '{LW, SW, RT, BEQ, J, ADDI, ANDI, ORI, SLTI};
        logic [5:0] op;
        step(1'b1, 1'b0, 6'd0, blank(4'd0));
        step(1'b1, 1'b1, 6'd0, blank(4'd0));
        step(1'b0, 1'b1, 6'd0, blank(4'd0));
        do_instr(LW, 0, 0);
        do_instr(SW, 0, 3);
        do_instr(ANDI, 0, 0);
        do_instr(ADDI, 1, 0);
        do_instr(BEQ, 0, 0);
        do_instr(J, 0, 0);
        do_instr(6'b111111, 0, 0);
        do_reset_mid_memrd();
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 9);
            if (k == 9) op = junk();
            else op = ops[k];
            do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
